// File: rtl/pipe_rca.sv
// pipe_rca: STAGES-deep pipelined ripple-carry adder/subtractor with valid/ready flow control.
// Define PIPE_RCA_OVF_EN to add the registered signed-overflow output ovf.
module pipe_rca #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             Cout,
`ifdef PIPE_RCA_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int unsigned SLICE = WIDTH / STAGES;

    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];
    logic             r_v [STAGES];

    logic [WIDTH-1:0] w_a    [STAGES];
    logic [WIDTH-1:0] w_b    [STAGES];
    logic [WIDTH-1:0] w_s    [STAGES];
    logic             w_ci   [STAGES];
    logic             w_co   [STAGES];
    logic             w_vin  [STAGES];
    logic             w_load [STAGES];
    logic             w_rc;
    logic             w_x;
    logic             w_y;
`ifdef PIPE_RCA_OVF_EN
    logic             w_ovf;
`endif

    // A stage may load when it is empty or its contents move on this edge.
    always_comb begin : flow
        w_load[STAGES-1] = !r_v[STAGES-1] || out_ready;
        for (int unsigned j = 0; j + 1 < STAGES; j++) begin
            w_load[STAGES-2-j] = !r_v[STAGES-2-j] || w_load[STAGES-1-j];
        end
        w_vin[0] = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            w_vin[k] = r_v[k-1];
        end
    end

    assign in_ready = w_load[0];

    always_comb begin : datapath
        w_rc = 1'b0;
        w_x  = 1'b0;
        w_y  = 1'b0;
`ifdef PIPE_RCA_OVF_EN
        w_ovf = 1'b0;
`endif
        w_a[0]  = a;
        w_b[0]  = sub ? ~b : b;
        w_s[0]  = '0;
        w_ci[0] = sub ? ~Cin : Cin;
        for (int unsigned k = 1; k < STAGES; k++) begin
            w_a[k]  = r_a[k-1];
            w_b[k]  = r_b[k-1];
            w_s[k]  = r_s[k-1];
            w_ci[k] = r_c[k-1];
        end
        // Each stage ripples its own slice and overwrites only those sum bits.
        for (int unsigned k = 0; k < STAGES; k++) begin
            w_rc = w_ci[k];
            for (int unsigned i = 0; i < SLICE; i++) begin
                w_x = w_a[k][k*SLICE + i];
                w_y = w_b[k][k*SLICE + i];
                w_s[k][k*SLICE + i] = w_x ^ w_y ^ w_rc;
`ifdef PIPE_RCA_OVF_EN
                if (k*SLICE + i == WIDTH-1) begin
                    w_ovf = w_rc ^ ((w_x & w_y) | (w_rc & (w_x ^ w_y)));
                end
`endif
                w_rc = (w_x & w_y) | (w_rc & (w_x ^ w_y));
            end
            w_co[k] = w_rc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
            end
            r_s[STAGES-1] <= '0;
            r_c[STAGES-1] <= 1'b0;
`ifdef PIPE_RCA_OVF_EN
            ovf <= 1'b0;
`endif
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_v[k] <= w_vin[k];
                    r_a[k] <= w_a[k];
                    r_b[k] <= w_b[k];
                    r_s[k] <= w_s[k];
                    r_c[k] <= w_co[k];
                end
            end
`ifdef PIPE_RCA_OVF_EN
            if (w_load[STAGES-1]) begin
                ovf <= w_ovf;
            end
`endif
        end
    end

    assign sum       = r_s[STAGES-1];
    assign Cout      = r_c[STAGES-1];
    assign out_valid = r_v[STAGES-1];

endmodule

// File: tb/tb_pipe_rca.sv
// tb_pipe_rca: directed self-checking bench for pipe_rca with a queue-based arithmetic model.
// Builds with or without PIPE_RCA_OVF_EN.
module tb_pipe_rca;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  a, b, sum;
    logic        Cin, sub, in_valid, in_ready, Cout, out_valid, out_ready;
    logic [15:0] a16, b16, sum16;
    logic        cin16, sub16, iv16, ir16, cout16, ov16, or16;
`ifdef PIPE_RCA_OVF_EN
    logic        ovf4, ovf16;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [5:0] q[$];
    logic [4:0] log_v[$];
    int         log_c[$];
    logic       stalled = 1'b0;
    logic [4:0] held;
    logic [5:0] exp6;

    logic [3:0] t35_a [5] = '{4'd1, 4'd3, 4'd5, 4'd15, 4'd10};
    logic [3:0] t35_b [5] = '{4'd1, 4'd2, 4'd6, 4'd1, 4'd10};
    logic       t35_c [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [4:0] t35_e [5] = '{5'b00010, 5'b00110, 5'b01011, 5'b10001, 5'b10100};
    logic [3:0] t37_a [4] = '{4'd7, 4'd3, 4'd9, 4'd12};
    logic [3:0] t37_b [4] = '{4'd8, 4'd5, 4'd2, 4'd4};
    logic       t37_c [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       t37_s [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [4:0] t37_e [4] = '{5'b01111, 5'b01110, 5'b10110, 5'b10001};

    pipe_rca #(.WIDTH(4), .STAGES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .Cin(Cin), .sub(sub),
        .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .Cout(Cout),
`ifdef PIPE_RCA_OVF_EN
        .ovf(ovf4),
`endif
        .out_valid(out_valid), .out_ready(out_ready)
    );

    pipe_rca #(.WIDTH(16), .STAGES(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .Cin(cin16), .sub(sub16),
        .in_valid(iv16), .in_ready(ir16), .sum(sum16), .Cout(cout16),
`ifdef PIPE_RCA_OVF_EN
        .ovf(ovf16),
`endif
        .out_valid(ov16), .out_ready(or16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Plain integer arithmetic: {ovf, Cout, sum}; for subtraction Cout=1 means no borrow.
    function automatic logic [5:0] model4(input logic [3:0] xa, input logic [3:0] xb,
                                          input logic ci, input logic s);
        int ua, ub, sa, sb, r, sr;
        logic co, ov;
        ua = int'(xa);
        ub = int'(xb);
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        if (!s) begin
            r  = ua + ub + int'(ci);
            co = (r > 15);
            sr = sa + sb + int'(ci);
        end else begin
            r  = ua - ub - int'(ci);
            co = (r >= 0);
            sr = sa - sb - int'(ci);
        end
        ov = (sr > 7) || (sr < -8);
        return {ov, co, 4'(r)};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) chk("stall_hold", {27'd0, Cout, sum}, {27'd0, held});
            if (in_valid && in_ready) q.push_back(model4(a, b, Cin, sub));
            stalled = out_valid && !out_ready;
            held = {Cout, sum};
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", {31'd0, out_valid}, 32'd0);
                end else begin
                    exp6 = q.pop_front();
`ifdef PIPE_RCA_OVF_EN
                    chk("model_out", {26'd0, ovf4, Cout, sum}, {26'd0, exp6});
`else
                    chk("model_out", {27'd0, Cout, sum}, {27'd0, exp6[4:0]});
`endif
                end
                log_v.push_back({Cout, sum});
                log_c.push_back(cyc);
            end
        end
    end

    task automatic run16(input logic [15:0] xa, input logic [15:0] xb, input logic ci,
                         input logic s, output logic [15:0] rs, output logic rc,
                         output logic ro, output int lat);
        int c0;
        @(posedge clk); #1;
        a16 = xa; b16 = xb; cin16 = ci; sub16 = s; iv16 = 1'b1;
        @(negedge clk);
        c0 = cyc;
        chk("w16_in_ready", {31'd0, ir16}, 32'd1);
        @(posedge clk); #1;
        iv16 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ov16 && lat < 20);
        lat = cyc - c0;
        rs = sum16;
        rc = cout16;
`ifdef PIPE_RCA_OVF_EN
        ro = ovf16;
`else
        ro = 1'b0;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int c0, n, acc, nout, idx;
        logic rdy;
        logic [15:0] rs;
        logic rc, ro;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; Cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; iv16 = 1'b0; or16 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {28'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, Cout}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Single op, latency measured in cycles from acceptance to out_valid.
        @(posedge clk); #1;
        a = 4'd0; b = 4'd0; Cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        c0 = cyc;
        chk("t034_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk("t034_latency", cyc - c0, 32'd4);
        chk("t034_sum", {28'd0, sum}, 32'd1);
        chk("t034_cout", {31'd0, Cout}, 32'd0);

        // Back-to-back stream.
        repeat (3) @(negedge clk);
        log_v.delete(); log_c.delete();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            a = t35_a[i]; b = t35_b[i]; Cin = t35_c[i]; sub = 1'b0; in_valid = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("t035_count", log_v.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < log_v.size()) begin
                chk("t035_value", {27'd0, log_v[i]}, {27'd0, t35_e[i]});
                chk("t035_consecutive", log_c[i] - log_c[0], i);
            end
        end

        // Stall with in_valid held high: capacity, hold, then ordered drain.
        log_v.delete(); log_c.delete();
        @(posedge clk); #1;
        out_ready = 1'b0;
        idx = 0;
        a = t37_a[0]; b = t37_b[0]; Cin = t37_c[0]; sub = t37_s[0]; in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rdy = in_ready;
            if (i < 4) chk("t037_in_ready_open", {31'd0, in_ready}, 32'd1);
            else       chk("t037_in_ready_full", {31'd0, in_ready}, 32'd0);
            if (rdy) acc++;
            @(posedge clk); #1;
            if (rdy && acc < 4) begin
                idx = acc;
                a = t37_a[idx]; b = t37_b[idx]; Cin = t37_c[idx]; sub = t37_s[idx];
            end
        end
        chk("t037_accepts", acc, 32'd4);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("t037_drained", log_v.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_v.size()) chk("t037_order", {27'd0, log_v[i]}, {27'd0, t37_e[i]});
        end

        // Fill the pipe, then reset for one cycle.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            a = t35_a[i]; b = t35_b[i]; Cin = t35_c[i]; sub = 1'b0; in_valid = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t038_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t038_sum", {28'd0, sum}, 32'd0);
        chk("t038_cout", {31'd0, Cout}, 32'd0);
        chk("t038_in_ready", {31'd0, in_ready}, 32'd1);
        nout = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) nout++;
        end
        chk("t038_no_stale", nout, 32'd0);

        // 16-bit instance.
        run16(16'h0005, 16'h0007, 1'b0, 1'b1, rs, rc, ro, n);
        chk("w16_sub_latency", n, 32'd4);
        chk("w16_sub_sum", {16'd0, rs}, 32'h0000FFFE);
        chk("w16_sub_cout", {31'd0, rc}, 32'd0);
`ifdef PIPE_RCA_OVF_EN
        chk("w16_sub_ovf", {31'd0, ro}, 32'd0);
`endif
        run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, n);
        chk("w16_add_sum", {16'd0, rs}, 32'h00008000);
        chk("w16_add_cout", {31'd0, rc}, 32'd0);
`ifdef PIPE_RCA_OVF_EN
        chk("w16_add_ovf", {31'd0, ro}, 32'd1);
`endif
        run16(16'h0007, 16'h0005, 1'b1, 1'b1, rs, rc, ro, n);
        chk("w16_subb_sum", {16'd0, rs}, 32'h00000001);
        chk("w16_subb_cout", {31'd0, rc}, 32'd1);

        chk("model_queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
